// File: rtl/pattern_gen.sv
// Video test-pattern source on the pixel clock.
// Takes row/column from the HDMI core and returns registered RGB two cycles later.
// Mode, solid colour and box position change only at start of frame, so no frame is torn.
module pattern_gen #(
    parameter int HACTIVE      = 1280,
    parameter int VACTIVE      = 720,
    parameter int COORD_W      = 11,
    parameter int COLOR_W      = 8,
    parameter int CHECKER_LOG2 = 5,
    parameter int BOX_SIZE     = 64,
    parameter int BOX_STEP     = 4,
    parameter int FCNT_W       = 16
) (
    input  logic                   pix_clk,
    input  logic                   reset,
    input  logic [2:0]             mode_req,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    input  logic [COORD_W-1:0]     row,
    input  logic [COORD_W-1:0]     column,
    output logic [COLOR_W-1:0]     r,
    output logic [COLOR_W-1:0]     g,
    output logic [COLOR_W-1:0]     b,
    output logic [2:0]             mode_active,
    output logic [FCNT_W-1:0]      frame_count
);

    localparam int                 PW     = COORD_W + 1;
    localparam logic [PW-1:0]      X_MAX  = PW'(HACTIVE - BOX_SIZE);
    localparam logic [PW-1:0]      Y_MAX  = PW'(VACTIVE - BOX_SIZE);
    localparam logic [PW-1:0]      STEP_W = PW'(BOX_STEP);
    localparam logic [PW-1:0]      BOX_W  = PW'(BOX_SIZE);
    localparam logic [COORD_W-1:0] H_LIM  = COORD_W'(HACTIVE);
    localparam logic [COORD_W-1:0] V_LIM  = COORD_W'(VACTIVE);
    localparam logic [COLOR_W-1:0] C_ONES = {COLOR_W{1'b1}};
    localparam logic [COLOR_W-1:0] C_ZERO = {COLOR_W{1'b0}};
    localparam logic [COLOR_W-1:0] C_GREY = {1'b1, {(COLOR_W-1){1'b0}}};

    // Left edge of colour bar k, fixed at elaboration.
    function automatic logic [COORD_W-1:0] bar_bound(input int k);
        bar_bound = COORD_W'((k * HACTIVE) / 8);
    endfunction

    // One bounce step along an axis; returns {dir_down, new_pos}.
    function automatic logic [COORD_W:0] axis_step(input logic [COORD_W-1:0] pos,
                                                   input logic dir_dn,
                                                   input logic [PW-1:0] lim);
        logic [PW-1:0] pos_w;
        pos_w = {1'b0, pos};
        if (!dir_dn) begin
            if ((pos_w + STEP_W) > lim) axis_step = {1'b1, lim[COORD_W-1:0]};
            else                        axis_step = {1'b0, pos + STEP_W[COORD_W-1:0]};
        end else begin
            if (pos_w < STEP_W)         axis_step = {1'b0, {COORD_W{1'b0}}};
            else                        axis_step = {1'b1, pos - STEP_W[COORD_W-1:0]};
        end
    endfunction

    // Frame-level state
    logic [COORD_W-1:0]   prev_row_q, prev_col_q;
    logic [2:0]           mode_q, mode_d;
    logic [3*COLOR_W-1:0] solid_q, solid_d;
    logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
    logic [COORD_W-1:0]   box_x_q, box_x_d, box_y_q, box_y_d;
    logic                 box_xdn_q, box_xdn_d, box_ydn_q, box_ydn_d;
    logic                 sof_s;

    // Stage 1
    logic                 s1_vld_q, s1_vld_d;
    logic [2:0]           s1_mode_q, s1_mode_d;
    logic                 s1_oor_q, s1_oor_d;
    logic [COLOR_W-1:0]   s1_rlo_q, s1_rlo_d, s1_clo_q, s1_clo_d;
    logic [2:0]           s1_bar_q, s1_bar_d;
    logic                 s1_chk_q, s1_chk_d;
    logic                 s1_box_q, s1_box_d;
    logic [3*COLOR_W-1:0] s1_solid_q, s1_solid_d;

    // Stage 2
    logic [COLOR_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
    logic [2:0]           bar_rgb_s;

    // Start of frame: entering (0,0) from any other coordinate.
    always_comb begin
        sof_s = (row == {COORD_W{1'b0}}) && (column == {COORD_W{1'b0}}) &&
                !((prev_row_q == {COORD_W{1'b0}}) && (prev_col_q == {COORD_W{1'b0}}));
    end

    // Next frame state; these values also feed stage 1 so the sof pixel uses them.
    always_comb begin
        mode_d    = mode_q;
        solid_d   = solid_q;
        fcnt_d    = fcnt_q;
        box_x_d   = box_x_q;
        box_y_d   = box_y_q;
        box_xdn_d = box_xdn_q;
        box_ydn_d = box_ydn_q;
        if (sof_s) begin
            if (mode_req <= 3'd4) mode_d = mode_req;
            else                  mode_d = mode_q;
            solid_d                = solid_rgb;
            fcnt_d                 = fcnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};
            {box_xdn_d, box_x_d}   = axis_step(box_x_q, box_xdn_q, X_MAX);
            {box_ydn_d, box_y_d}   = axis_step(box_y_q, box_ydn_q, Y_MAX);
        end else begin
            mode_d = mode_q;
        end
    end

    // Stage 1: coordinates, effective mode and per-pattern decisions.
    always_comb begin
        s1_vld_d   = 1'b1;
        s1_mode_d  = mode_d;
        s1_solid_d = solid_d;
        s1_rlo_d   = row[COLOR_W-1:0];
        s1_clo_d   = column[COLOR_W-1:0];
        s1_oor_d   = (column >= H_LIM) || (row >= V_LIM);
        s1_bar_d   = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (column >= bar_bound(k)) s1_bar_d = 3'(k);
            else                        s1_bar_d = s1_bar_d;
        end
        s1_chk_d = row[CHECKER_LOG2] ^ column[CHECKER_LOG2];
        s1_box_d = ({1'b0, column} >= {1'b0, box_x_d}) &&
                   ({1'b0, column} <  ({1'b0, box_x_d} + BOX_W)) &&
                   ({1'b0, row}    >= {1'b0, box_y_d}) &&
                   ({1'b0, row}    <  ({1'b0, box_y_d} + BOX_W));
    end

    // Stage 2: final colour selection.
    always_comb begin
        r_d       = C_ZERO;
        g_d       = C_ZERO;
        b_d       = C_ZERO;
        bar_rgb_s = 3'b000;
        if (!s1_vld_q || s1_oor_q) begin
            r_d = C_ZERO;
        end else begin
            case (s1_mode_q)
                3'd0: begin
                    r_d = s1_rlo_q;
                    g_d = s1_clo_q;
                    b_d = C_ONES - {1'b0, s1_rlo_q[COLOR_W-1:1]} - {1'b0, s1_clo_q[COLOR_W-1:1]};
                end
                3'd1: begin
                    case (s1_bar_q)
                        3'd0:    bar_rgb_s = 3'b111;
                        3'd1:    bar_rgb_s = 3'b110;
                        3'd2:    bar_rgb_s = 3'b011;
                        3'd3:    bar_rgb_s = 3'b010;
                        3'd4:    bar_rgb_s = 3'b101;
                        3'd5:    bar_rgb_s = 3'b100;
                        3'd6:    bar_rgb_s = 3'b001;
                        default: bar_rgb_s = 3'b000;
                    endcase
                    r_d = {COLOR_W{bar_rgb_s[2]}};
                    g_d = {COLOR_W{bar_rgb_s[1]}};
                    b_d = {COLOR_W{bar_rgb_s[0]}};
                end
                3'd2: begin
                    if (!s1_chk_q) begin r_d = C_ONES; g_d = C_ONES; b_d = C_ONES; end
                    else           begin r_d = C_ZERO; g_d = C_ZERO; b_d = C_ZERO; end
                end
                3'd3: begin
                    r_d = s1_solid_q[3*COLOR_W-1:2*COLOR_W];
                    g_d = s1_solid_q[2*COLOR_W-1:COLOR_W];
                    b_d = s1_solid_q[COLOR_W-1:0];
                end
                3'd4: begin
                    if (s1_box_q) begin r_d = C_ONES; g_d = C_ONES; b_d = C_ONES; end
                    else          begin r_d = C_GREY; g_d = C_GREY; b_d = C_GREY; end
                end
                default: begin
                    r_d = C_ZERO;
                end
            endcase
        end
    end

    // All state registers; everything clears at once on reset.
    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            prev_row_q <= {COORD_W{1'b0}};
            prev_col_q <= {COORD_W{1'b0}};
            mode_q     <= 3'd0;
            solid_q    <= {(3*COLOR_W){1'b0}};
            fcnt_q     <= {FCNT_W{1'b0}};
            box_x_q    <= {COORD_W{1'b0}};
            box_y_q    <= {COORD_W{1'b0}};
            box_xdn_q  <= 1'b0;
            box_ydn_q  <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_mode_q  <= 3'd0;
            s1_oor_q   <= 1'b0;
            s1_rlo_q   <= C_ZERO;
            s1_clo_q   <= C_ZERO;
            s1_bar_q   <= 3'd0;
            s1_chk_q   <= 1'b0;
            s1_box_q   <= 1'b0;
            s1_solid_q <= {(3*COLOR_W){1'b0}};
            r_q        <= C_ZERO;
            g_q        <= C_ZERO;
            b_q        <= C_ZERO;
        end else begin
            prev_row_q <= row;
            prev_col_q <= column;
            mode_q     <= mode_d;
            solid_q    <= solid_d;
            fcnt_q     <= fcnt_d;
            box_x_q    <= box_x_d;
            box_y_q    <= box_y_d;
            box_xdn_q  <= box_xdn_d;
            box_ydn_q  <= box_ydn_d;
            s1_vld_q   <= s1_vld_d;
            s1_mode_q  <= s1_mode_d;
            s1_oor_q   <= s1_oor_d;
            s1_rlo_q   <= s1_rlo_d;
            s1_clo_q   <= s1_clo_d;
            s1_bar_q   <= s1_bar_d;
            s1_chk_q   <= s1_chk_d;
            s1_box_q   <= s1_box_d;
            s1_solid_q <= s1_solid_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign mode_active = mode_q;
    assign frame_count = fcnt_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: behavioural frame/pixel model, per-cycle compare,
// plus literal pins from hand-computed pattern values.
`timescale 1ns/1ps
module tb_pattern_gen;

    localparam int H = 1280;
    localparam int V = 720;
    localparam int BOX = 64;
    localparam int XMAX = H - BOX;
    localparam int YMAX = V - BOX;

    logic        pix_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [2:0]  mode_req = 3'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic [10:0] row = 11'd0;
    logic [10:0] column = 11'd0;
    logic [7:0]  r, g, b;
    logic [2:0]  mode_active;
    logic [15:0] frame_count;

    pattern_gen dut (
        .pix_clk     (pix_clk),
        .reset       (reset),
        .mode_req    (mode_req),
        .solid_rgb   (solid_rgb),
        .row         (row),
        .column      (column),
        .r           (r),
        .g           (g),
        .b           (b),
        .mode_active (mode_active),
        .frame_count (frame_count)
    );

    always #5 pix_clk = ~pix_clk;

    typedef struct packed {
        logic [23:0] rgb;
        logic [2:0]  mode;
        logic [15:0] fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Model state
    int          m_mode, m_fcnt, m_bx, m_by, m_dx, m_dy, m_prow, m_pcol;
    logic [23:0] m_solid;
    logic [2:0]  nxt_mode = 3'd0;
    logic [23:0] nxt_solid = 24'h0;
    bit          rel_pending = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_fcnt = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
        m_prow = 0; m_pcol = 0; m_solid = 24'h0;
    endtask

    // Expected outputs for one presented pixel, from the pattern rules directly.
    task automatic model_px(input int rw, input int cl, output exp_t e);
        bit sof;
        logic [23:0] c;
        sof = (rw == 0 && cl == 0) && !(m_prow == 0 && m_pcol == 0);
        m_prow = rw;
        m_pcol = cl;
        if (sof) begin
            if (int'(mode_req) <= 4) m_mode = int'(mode_req);
            m_solid = solid_rgb;
            m_fcnt  = (m_fcnt + 1) % 65536;
            m_bx += 4 * m_dx;
            if (m_bx > XMAX) begin m_bx = XMAX; m_dx = -1; end
            else if (m_bx < 0) begin m_bx = 0; m_dx = 1; end
            m_by += 4 * m_dy;
            if (m_by > YMAX) begin m_by = YMAX; m_dy = -1; end
            else if (m_by < 0) begin m_by = 0; m_dy = 1; end
        end
        if (cl >= H || rw >= V) c = 24'h0;
        else begin
            case (m_mode)
                0: c = {8'(rw % 256), 8'(cl % 256), 8'(255 - (rw % 256) / 2 - (cl % 256) / 2)};
                1: c = bars[(cl * 8) / H];
                2: c = ((((rw / 32) + (cl / 32)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
                3: c = m_solid;
                default: c = (cl >= m_bx && cl < m_bx + BOX && rw >= m_by && rw < m_by + BOX)
                             ? 24'hFFFFFF : 24'h808080;
            endcase
        end
        e.rgb  = c;
        e.mode = 3'(m_mode);
        e.fcnt = 16'(m_fcnt);
    endtask

    // Present one pixel (with pending mode/colour) just after a rising edge.
    task automatic step(input int rw, input int cl);
        exp_t e;
        @(posedge pix_clk);
        #1;
        if (rel_pending) begin
            reset = 1'b0;
            exp_q.delete();
            model_reset();
            rel_pending = 1'b0;
        end
        mode_req  = nxt_mode;
        solid_rgb = nxt_solid;
        row       = 11'(rw);
        column    = 11'(cl);
        model_px(rw, cl, e);
        exp_q.push_back(e);
    endtask

    // Hold a pixel long enough for it to reach the outputs, then check a literal.
    task automatic pin(input string nm, input int rw, input int cl, input logic [23:0] expv);
        step(rw, cl);
        step(rw, cl);
        step(rw, cl);
        chk(nm, 32'({r, g, b}), 32'(expv));
    endtask

    // Per-cycle comparison against the model, two cycles behind the presented pixel.
    always @(negedge pix_clk) begin
        if (!reset && exp_q.size() >= 3) begin
            chk("rgb", 32'({r, g, b}), 32'(exp_q[0].rgb));
            chk("mode_active", 32'(mode_active), 32'(exp_q[1].mode));
            chk("frame_count", 32'(frame_count), 32'(exp_q[1].fcnt));
            void'(exp_q.pop_front());
        end
    end

    task automatic do_reset();
        @(posedge pix_clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge pix_clk);
        rel_pending = 1'b1;
    endtask

    initial begin
        int rr, cc;
        model_reset();
        repeat (3) @(posedge pix_clk);
        #1;
        chk("reset_rgb", 32'({r, g, b}), 32'h0);
        chk("reset_mode", 32'(mode_active), 32'h0);
        chk("reset_fcnt", 32'(frame_count), 32'h0);
        rel_pending = 1'b1;

        // Gradient sweep
        nxt_mode = 3'd0;
        for (int c = 0; c < 16; c++) step(3, c);
        pin("grad_c10", 3, 10, {8'd3, 8'd10, 8'd249});

        // Mode request mid-frame must wait for the next frame
        nxt_mode = 3'd1;
        pin("midframe_hold", 5, 100, {8'd5, 8'd100, 8'd203});
        chk("mode_still0", 32'(mode_active), 32'h0);
        pin("bars_white", 0, 0, 24'hFFFFFF);
        chk("mode_now1", 32'(mode_active), 32'h1);
        pin("bars_yellow", 0, 160, 24'hFFFF00);
        pin("bars_blue", 0, 1119, 24'h0000FF);
        pin("bars_black", 0, 1279, 24'h000000);

        // Checker boundaries
        nxt_mode = 3'd2;
        pin("chk_c0", 0, 0, 24'hFFFFFF);
        pin("chk_c31", 0, 31, 24'hFFFFFF);
        pin("chk_c32", 0, 32, 24'h000000);
        pin("chk_c63", 0, 63, 24'h000000);
        pin("chk_c64", 0, 64, 24'hFFFFFF);

        // Reserved mode request and out-of-range pixels
        nxt_mode = 3'd7;
        pin("rsvd_keep", 0, 0, 24'hFFFFFF);
        chk("mode_kept2", 32'(mode_active), 32'h2);
        pin("oor_col", 0, 1280, 24'h000000);
        pin("oor_row", 720, 5, 24'h000000);

        // Solid colour latched per frame
        nxt_mode  = 3'd3;
        nxt_solid = 24'h123456;
        step(0, 0);
        nxt_solid = 24'hABCDEF;
        pin("solid_old", 10, 10, 24'h123456);
        step(0, 0);
        pin("solid_new", 10, 10, 24'hABCDEF);

        // Asynchronous reset mid-line
        step(20, 20);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rgb", 32'({r, g, b}), 32'h0);
        chk("async_fcnt", 32'(frame_count), 32'h0);
        chk("async_mode", 32'(mode_active), 32'h0);
        rel_pending = 1'b1;
        pin("post_rst_grad", 3, 10, {8'd3, 8'd10, 8'd249});
        step(0, 0);
        step(1, 1);
        step(1, 1);
        chk("post_rst_fcnt", 32'(frame_count), 32'h1);

        // Randomized frames with mid-frame request changes
        for (int f = 0; f < 60; f++) begin
            nxt_mode  = 3'($urandom_range(0, 7));
            nxt_solid = 24'($urandom);
            step(0, 0);
            for (int p = 0; p < 6; p++) begin
                if ($urandom_range(0, 3) == 0) nxt_mode = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) nxt_solid = 24'($urandom);
                step(int'($urandom_range(0, 760)), int'($urandom_range(0, 1330)));
            end
        end

        // Bouncing box over 400 frames from a fresh reset
        do_reset();
        nxt_mode = 3'd4;
        step(5, 5);
        for (int f = 1; f <= 400; f++) begin
            step(0, 0);
            if (f == 1) begin
                pin("box_f1_in", 4, 4, 24'hFFFFFF);
                pin("box_f1_out", 4, 3, 24'h808080);
            end else if (f == 164) begin
                pin("box_f164_in", 656, 656, 24'hFFFFFF);
                pin("box_f164_out", 655, 656, 24'h808080);
            end else if (f == 304) begin
                pin("box_f304_in", 100, 1216, 24'hFFFFFF);
                pin("box_f304_out", 100, 1215, 24'h808080);
                chk("box_f304_fcnt", 32'(frame_count), 32'd304);
            end
            for (int p = 0; p < 3; p++) begin
                rr = m_by + int'($urandom_range(0, BOX + 1)) - 1;
                cc = m_bx + int'($urandom_range(0, BOX + 1)) - 1;
                if (rr < 0) rr = 0;
                if (cc < 0) cc = 0;
                if (rr == 0 && cc == 0) cc = 1;
                step(rr, cc);
            end
            step(int'($urandom_range(1, 740)), int'($urandom_range(0, 1300)));
        end
        step(1, 1);
        step(1, 1);
        step(1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
